imem_loader: RTL



---
 rtl/loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 33 +++
 rtl/byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 123 ++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StHdr,
    StLoad,
    StWrite,
    StDone,
    StErr
  } loader_state_e;

  // Bytes per packed word; the header is one word.
  localparam int unsigned HDR_BYTES = 4;

  // Full-word byte enables for the IM SRAM.
  localparam logic [3:0] IM_WEN_FULL = 4'b1111;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IM SRAM write port of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 16
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        im_w_en;
  logic [ADDR_W-1:0] im_address;
  logic [31:0]       im_write_data;

  // Byte source side: drives the stream, observes the SRAM port.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  im_w_en,
    input  im_address,
    input  im_write_data
  );

  // Loader side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output im_w_en,
    output im_address,
    output im_write_data
  );

endinterface

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid marks the 4th byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_fire,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  // Only the three earlier bytes need storage; the 4th is taken straight from byte_in.
  logic [23:0] shift_q;

  // Byte counter and shift register advance on each accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_fire) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {byte_in, shift_q[23:8]};
    end
  end

  assign word_out   = {byte_in, shift_q};
  assign word_valid = byte_fire && (cnt_q == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a word-count header and that many words from a byte stream,
// writes them into the IM SRAM, then releases the core from reset.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 16384
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus_io,
  output logic         core_rst,
  output logic         done,
  output logic         error,
  output logic [14:0]  words_loaded,
  output logic [31:0]  checksum
);

  loader_state_e     state_q;
  logic [31:0]       n_q;
  logic [14:0]       word_idx_q;
  logic [31:0]       checksum_q;
  logic [ADDR_W-1:0] im_address_q;
  logic [31:0]       im_write_data_q;
  logic [3:0]        im_w_en_q;
  logic              core_rst_q;
  logic              done_q;
  logic              error_q;

  logic        in_ready;
  logic        byte_fire;
  logic [31:0] word;
  logic        word_valid;
  logic [31:0] next_count;
  logic [31:0] addr_full;

  // Ready is gated by rst directly so it drops in the very cycle reset is applied.
  assign in_ready  = !rst && ((state_q == StHdr) || (state_q == StLoad));
  assign byte_fire = bus_io.in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (bus_io.in_data),
    .byte_fire  (byte_fire),
    .word_out   (word),
    .word_valid (word_valid)
  );

  assign next_count = {17'd0, word_idx_q} + 32'd1;
  // Computed at 32 bits, then truncated so the address wraps modulo 2^ADDR_W.
  assign addr_full  = 32'(BASE_ADDR) + {15'd0, word_idx_q, 2'b00};

  // Loader FSM with registered outputs, index and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StHdr;
      n_q             <= 32'd0;
      word_idx_q      <= 15'd0;
      checksum_q      <= 32'd0;
      im_address_q    <= BASE_ADDR;
      im_write_data_q <= 32'd0;
      im_w_en_q       <= 4'b0000;
      core_rst_q      <= 1'b1;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      im_w_en_q <= 4'b0000;
      unique case (state_q)
        StHdr: begin
          if (word_valid) begin
            n_q <= word;
            if (word == 32'd0) begin
              state_q    <= StDone;
              core_rst_q <= 1'b0;
              done_q     <= 1'b1;
            end else if (word > MAX_WORDS) begin
              state_q <= StErr;
              error_q <= 1'b1;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (word_valid) begin
            im_write_data_q <= word;
            im_address_q    <= ADDR_W'(addr_full);
            im_w_en_q       <= IM_WEN_FULL;
            state_q         <= StWrite;
          end
        end
        StWrite: begin
          word_idx_q <= word_idx_q + 15'd1;
          checksum_q <= checksum_q + im_write_data_q;
          if (next_count == n_q) begin
            state_q    <= StDone;
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            state_q <= StLoad;
          end
        end
        StDone: ;
        StErr:  ;
        default: state_q <= StHdr;
      endcase
    end
  end

  assign bus_io.in_ready      = in_ready;
  assign bus_io.im_w_en       = im_w_en_q;
  assign bus_io.im_address    = im_address_q;
  assign bus_io.im_write_data = im_write_data_q;

  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = word_idx_q;
  assign checksum     = checksum_q;

endmodule
